wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the 64-bit pipeline and the writer end of the register-file port that instruction decode reads. It accepts completed instructions from the memory stage over a valid/ready handshake and buffers them in a 2-entry skid FIFO. For each entry it selects ALU result or load data and drives the register-file write port. It also keeps a pending-write scoreboard that decode queries for RAW hazards.

## Interface
Parameters:
- XLEN, 64, datapath width
- FIFO_DEPTH, 2, skid buffer entries (fixed at 2; other values unsupported)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  memory stage has an instruction
- in_ready  out  1  stage can accept; high when FIFO count < 2
- in_rd  in  5  destination register
- in_reg_write  in  1  instruction writes rd
- in_mem_to_reg  in  1  1 = write in_mem_data, 0 = write in_alu_result
- in_alu_result  in  XLEN  ALU result
- in_mem_data  in  XLEN  load data
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  write address
- rf_wdata  out  XLEN  write data
- rf_wready  in  1  register file accepts the write this cycle
- issue_valid  in  1  decode issues an instruction this cycle
- issue_rd  in  5  its destination
- issue_reg_write  in  1  it writes a register
- q_rs1, q_rs2  in  5 each  decode source registers
- hazard_rs1, hazard_rs2  out  1 each  source has a pending write
- pending  out  32  scoreboard mask
- retire_count  out  64  instructions retired
- byp_valid  out  1  head entry is a forwardable write
- byp_rd  out  5  head destination
- byp_data  out  XLEN  head write data

## Operation
- Push: when in_valid && in_ready, the entry {rd, reg_write, selected data} is written at the FIFO tail. The data mux is resolved at push time.
- Head: rf_we = head_valid && head.reg_write && head.rd != 0. rf_waddr and rf_wdata are driven from the head whenever head_valid, and are 0 otherwise.
- Pop:
  - A writing head pops on rf_we && rf_wready.
  - A non-writing head (reg_write=0 or rd=0) pops unconditionally in the cycle it is at the head.
- Push and pop in the same cycle are allowed when count is 1. The count is unchanged.
- When count==2, in_ready is 0 even if a pop occurs that cycle. There is no full-path bypass.
- Scoreboard set: on issue_valid && issue_reg_write && issue_rd != 0, set pending[issue_rd].
- Scoreboard clear: when a writing head pops, clear pending[head.rd].
- Set and clear of the same bit in one cycle: set wins, because the issued instruction is younger.
- pending[0] is always 0.
- hazard_rsN = pending[q_rsN], combinational.
- retire_count increments by 1 on every pop, writing or not. It wraps at 2^64 to 0.

## Timing
- Reset values:
  - in_ready = 1
  - rf_we = 0, rf_waddr = 0, rf_wdata = 0
  - pending = 0, hazard_rs1 = hazard_rs2 = 0
  - retire_count = 0
  - byp_valid = 0, byp_rd = 0, byp_data = 0
  - FIFO empty
- Latency: an entry accepted at edge N appears on rf_* in cycle N+1. With rf_wready=1 it pops at edge N+1. Throughput is 1 per cycle.
- in_ready and rf_we are pure functions of registered state. There is no combinational path from in_valid to in_ready or to rf_*.
- rf_wready held low: the head is stable and the FIFO fills after two pushes, after which in_ready drops.
- Reset asserted mid-operation: all entries are discarded, the scoreboard is cleared and the counter is zeroed immediately.

## Configuration
- WB_BYPASS_EN defined:
  - byp_valid = rf_we.
  - byp_rd and byp_data mirror the head, so decode can forward the in-flight value.
- WB_BYPASS_EN undefined:
  - byp_* ports remain present and are tied to 0.
  - Decode relies on the hazard outputs only.

## Structure
- Package wb_pkg contains:
  - XLEN and NUM_REGS=32
  - typedef wb_entry_t {rd[4:0], reg_write, data[XLEN-1:0]}
- Sub-module wb_fifo2: 2-entry FIFO of wb_entry_t with push/pop, head, count, full and empty.
- Scoreboard, retire counter and output muxing live in wb_stage.

## Test plan
- Load writeback:
  - Stimulus: push rd=5, reg_write=1, mem_to_reg=1, mem_data=0xDEAD, alu=0x1, with rf_wready=1.
  - Required: next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEAD; retire_count becomes 1.
- x0 suppression:
  - Stimulus: push rd=0, reg_write=1.
  - Required: rf_we stays 0; the entry pops in one cycle; retire_count increments; pending[0]=0.
- Backpressure:
  - Stimulus: rf_wready=0, push three back-to-back entries.
  - Required: the first two are accepted; in_ready=0 on the third cycle.
  - Then raise rf_wready: the entries drain in order, one per cycle.
- Scoreboard:
  - Stimulus: issue rd=7.
  - Required: pending[7]=1 and hazard_rs1=1 for q_rs1=7.
  - Stimulus: writeback of rd=7 pops in the same cycle as a new issue of rd=7.
  - Required: pending[7] remains 1.
- Reset mid-stream:
  - Stimulus: with 2 entries held and pending=0x80, assert rst_n=0.
  - Required: immediately in_ready=1, rf_we=0, pending=0, retire_count=0.
- Bypass:
  - With WB_BYPASS_EN defined and rf_wready=0 holding rd=3, data=0x42: byp_valid=1, byp_rd=3, byp_data=0x42.
  - With WB_BYPASS_EN undefined: all byp_* outputs are 0.

Source files
------------

// File: rtl/wb_pkg.sv
// ============================================================================
// Module      : wb_pkg
// Description : Shared types and constants for the writeback stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_pkg;

    localparam int XLEN     = 64;
    localparam int NUM_REGS = 32;

    // One buffered writeback; the ALU/load data mux is already resolved.
    typedef struct packed {
        logic [4:0]      rd;
        logic            reg_write;
        logic [XLEN-1:0] data;
    } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_fifo2.sv
// ============================================================================
// Module      : wb_fifo2
// Description : Two-entry skid FIFO of writeback entries with head, count,
//               full and empty status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_fifo2
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  wb_entry_t  push_data_i,
    input  logic       pop_i,
    output wb_entry_t  head_o,
    output logic [1:0] count_o,
    output logic       full_o,
    output logic       empty_o
);

    wb_entry_t  mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       do_push;
    logic       do_pop;

    assign full_o  = (count_q == 2'(DEPTH));
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Guard against overflow/underflow regardless of caller behaviour.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage, pointers and occupancy; reset discards all entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
// ============================================================================
// Module      : wb_stage
// Description : Writeback stage: skid-buffers completed instructions, drives
//               the register-file write port, tracks pending writes for RAW
//               hazard detection and counts retired instructions.
//               Define WB_BYPASS_EN to expose the head write on byp_*;
//               otherwise byp_* are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_stage #(
    parameter int XLEN       = 64,
    parameter int FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rd,
    input  logic            in_reg_write,
    input  logic            in_mem_to_reg,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_mem_data,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    input  logic            rf_wready,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic            issue_reg_write,
    input  logic [4:0]      q_rs1,
    input  logic [4:0]      q_rs2,
    output logic            hazard_rs1,
    output logic            hazard_rs2,
    output logic [31:0]     pending,
    output logic [63:0]     retire_count,
    output logic            byp_valid,
    output logic [4:0]      byp_rd,
    output logic [XLEN-1:0] byp_data
);

    import wb_pkg::*;

    wb_entry_t   push_entry;
    wb_entry_t   head;
    logic [1:0]  fifo_count;
    logic        fifo_full;
    logic        fifo_empty;
    logic        head_valid;
    logic        head_writes;
    logic        push;
    logic        pop;
    logic [31:0] pending_q;
    logic [31:0] pending_d;
    logic [63:0] retire_q;

    // in_ready depends only on registered occupancy, never on in_valid.
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;

    // Data mux resolved at push time so the head holds the final value.
    assign push_entry.rd        = in_rd;
    assign push_entry.reg_write = in_reg_write;
    assign push_entry.data      = in_mem_to_reg ? in_mem_data : in_alu_result;

    wb_fifo2 #(
        .DEPTH       (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign head_valid  = (fifo_count != 2'd0);
    assign head_writes = head.reg_write && (head.rd != 5'd0);

    // Writes to x0 or non-writing entries retire without waiting on the RF.
    assign rf_we    = head_valid && head_writes;
    assign rf_waddr = head_valid ? head.rd : 5'd0;
    assign rf_wdata = head_valid ? head.data : '0;
    assign pop      = head_valid && (!head_writes || rf_wready);

    // Scoreboard next state: clear on retiring write, then a younger issue
    // to the same register re-sets the bit.
    always_comb begin
        pending_d = pending_q;
        if (pop && head_writes) begin
            pending_d[head.rd] = 1'b0;
        end
        if (issue_valid && issue_reg_write && (issue_rd != 5'd0)) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Scoreboard and retire counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            retire_q  <= '0;
        end else begin
            pending_q <= pending_d;
            if (pop) begin
                retire_q <= retire_q + 64'd1;
            end
        end
    end

    assign pending      = pending_q;
    assign retire_count = retire_q;
    assign hazard_rs1   = pending_q[q_rs1];
    assign hazard_rs2   = pending_q[q_rs2];

`ifdef WB_BYPASS_EN
    assign byp_valid = rf_we;
    assign byp_rd    = rf_waddr;
    assign byp_data  = rf_wdata;
`else
    assign byp_valid = 1'b0;
    assign byp_rd    = 5'd0;
    assign byp_data  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// ============================================================================
// Module      : tb_wb_stage
// Description : Self-checking bench for wb_stage with a queue-based
//               reference model of the skid FIFO, scoreboard and counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        in_mem_to_reg;
    logic [63:0] in_alu_result;
    logic [63:0] in_mem_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        rf_wready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_reg_write;
    logic [4:0]  q_rs1;
    logic [4:0]  q_rs2;
    logic        hazard_rs1;
    logic        hazard_rs2;
    logic [31:0] pending;
    logic [63:0] retire_count;
    logic        byp_valid;
    logic [4:0]  byp_rd;
    logic [63:0] byp_data;

    int n_cmp;
    int n_err;

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic [63:0] data;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pending;
    logic [63:0] m_retire;

    wb_stage #(
        .XLEN            (64),
        .FIFO_DEPTH      (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_rd           (in_rd),
        .in_reg_write    (in_reg_write),
        .in_mem_to_reg   (in_mem_to_reg),
        .in_alu_result   (in_alu_result),
        .in_mem_data     (in_mem_data),
        .rf_we           (rf_we),
        .rf_waddr        (rf_waddr),
        .rf_wdata        (rf_wdata),
        .rf_wready       (rf_wready),
        .issue_valid     (issue_valid),
        .issue_rd        (issue_rd),
        .issue_reg_write (issue_reg_write),
        .q_rs1           (q_rs1),
        .q_rs2           (q_rs2),
        .hazard_rs1      (hazard_rs1),
        .hazard_rs2      (hazard_rs2),
        .pending         (pending),
        .retire_count    (retire_count),
        .byp_valid       (byp_valid),
        .byp_rd          (byp_rd),
        .byp_data        (byp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_in(input logic [4:0] rd, input logic rw, input logic m2r,
                           input logic [63:0] alu, input logic [63:0] mem);
        in_valid      = 1'b1;
        in_rd         = rd;
        in_reg_write  = rw;
        in_mem_to_reg = m2r;
        in_alu_result = alu;
        in_mem_data   = mem;
    endtask

    // Reference model: checks outputs at the falling edge, then advances
    // the model to the state the next rising edge should produce.
    always @(negedge clk) begin
        logic        m_wr;
        logic        m_pop;
        logic        m_push;
        logic        m_ready;
        logic [4:0]  e_addr;
        logic [63:0] e_data;
        ent_t        h;
        ent_t        n;
        if (!rst_n) begin
            mq.delete();
            m_pending = '0;
            m_retire  = '0;
            chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
            chk("rst_rf_we", {63'd0, rf_we}, 64'd0);
            chk("rst_rf_waddr", {59'd0, rf_waddr}, 64'd0);
            chk("rst_rf_wdata", rf_wdata, 64'd0);
            chk("rst_pending", {32'd0, pending}, 64'd0);
            chk("rst_retire", retire_count, 64'd0);
            chk("rst_byp_valid", {63'd0, byp_valid}, 64'd0);
        end else begin
            m_ready = (mq.size() < 2);
            m_wr    = 1'b0;
            e_addr  = 5'd0;
            e_data  = 64'd0;
            if (mq.size() > 0) begin
                h      = mq[0];
                m_wr   = h.rw && (h.rd != 5'd0);
                e_addr = h.rd;
                e_data = h.data;
            end
            chk("in_ready", {63'd0, in_ready}, {63'd0, m_ready});
            chk("rf_we", {63'd0, rf_we}, {63'd0, m_wr});
            chk("rf_waddr", {59'd0, rf_waddr}, {59'd0, e_addr});
            chk("rf_wdata", rf_wdata, e_data);
            chk("pending", {32'd0, pending}, {32'd0, m_pending});
            chk("retire_count", retire_count, m_retire);
            chk("hazard_rs1", {63'd0, hazard_rs1}, {63'd0, m_pending[q_rs1]});
            chk("hazard_rs2", {63'd0, hazard_rs2}, {63'd0, m_pending[q_rs2]});
`ifdef WB_BYPASS_EN
            chk("byp_valid", {63'd0, byp_valid}, {63'd0, m_wr});
            chk("byp_rd", {59'd0, byp_rd}, {59'd0, e_addr});
            chk("byp_data", byp_data, e_data);
`else
            chk("byp_valid", {63'd0, byp_valid}, 64'd0);
            chk("byp_rd", {59'd0, byp_rd}, 64'd0);
            chk("byp_data", byp_data, 64'd0);
`endif
            m_pop  = (mq.size() > 0) && (!m_wr || rf_wready);
            m_push = in_valid && m_ready;
            if (m_pop && m_wr) m_pending[e_addr] = 1'b0;
            if (issue_valid && issue_reg_write && issue_rd != 5'd0) m_pending[issue_rd] = 1'b1;
            m_pending[0] = 1'b0;
            if (m_pop) begin
                void'(mq.pop_front());
                m_retire = m_retire + 64'd1;
            end
            if (m_push) begin
                n.rd   = in_rd;
                n.rw   = in_reg_write;
                n.data = in_mem_to_reg ? in_mem_data : in_alu_result;
                mq.push_back(n);
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; in_rd = 5'd0; in_reg_write = 1'b0; in_mem_to_reg = 1'b0;
        in_alu_result = 64'd0; in_mem_data = 64'd0;
        rf_wready = 1'b1;
        issue_valid = 1'b0; issue_rd = 5'd0; issue_reg_write = 1'b0;
        q_rs1 = 5'd0; q_rs2 = 5'd0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Load writeback selects mem data.
        push_in(5'd5, 1'b1, 1'b1, 64'h1, 64'hDEAD);
        tick();
        in_valid = 1'b0;
        chk("load_we", {63'd0, rf_we}, 64'd1);
        chk("load_waddr", {59'd0, rf_waddr}, 64'd5);
        chk("load_wdata", rf_wdata, 64'hDEAD);
        tick();
        chk("load_retire", retire_count, 64'd1);

        // x0 write suppressed but still retired.
        push_in(5'd0, 1'b1, 1'b0, 64'h55, 64'h0);
        tick();
        in_valid = 1'b0;
        chk("x0_we", {63'd0, rf_we}, 64'd0);
        tick();
        chk("x0_retire", retire_count, 64'd2);
        chk("x0_pending0", {63'd0, pending[0]}, 64'd0);

        // Backpressure: two accepted, third refused, then drain in order.
        rf_wready = 1'b0;
        push_in(5'd1, 1'b1, 1'b0, 64'hA1, 64'h0);
        tick();
        push_in(5'd2, 1'b1, 1'b0, 64'hB2, 64'h0);
        tick();
        push_in(5'd3, 1'b1, 1'b0, 64'hC3, 64'h0);
        chk("bp_ready_low", {63'd0, in_ready}, 64'd0);
        tick();
        in_valid  = 1'b0;
        rf_wready = 1'b1;
        chk("bp_head_first", {59'd0, rf_waddr}, 64'd1);
        tick();
        chk("bp_head_second", {59'd0, rf_waddr}, 64'd2);
        repeat (2) tick();

        // Scoreboard set, and set-wins-over-clear on the same register.
        issue_valid = 1'b1; issue_rd = 5'd7; issue_reg_write = 1'b1; q_rs1 = 5'd7;
        tick();
        issue_valid = 1'b0;
        chk("sb_pending7", {63'd0, pending[7]}, 64'd1);
        chk("sb_hazard1", {63'd0, hazard_rs1}, 64'd1);
        push_in(5'd7, 1'b1, 1'b0, 64'h77, 64'h0);
        tick();
        in_valid = 1'b0;
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        chk("sb_set_wins", {63'd0, pending[7]}, 64'd1);
        tick();

        // Randomised traffic against the model.
        for (int i = 0; i < 300; i++) begin
            in_valid        = 1'($urandom_range(0, 1));
            in_rd           = 5'($urandom_range(0, 31));
            in_reg_write    = ($urandom_range(0, 3) != 0);
            in_mem_to_reg   = 1'($urandom_range(0, 1));
            in_alu_result   = {$urandom(), $urandom()};
            in_mem_data     = {$urandom(), $urandom()};
            rf_wready       = ($urandom_range(0, 3) != 0);
            issue_valid     = 1'($urandom_range(0, 1));
            issue_rd        = 5'($urandom_range(0, 31));
            issue_reg_write = 1'($urandom_range(0, 1));
            q_rs1           = 5'($urandom_range(0, 31));
            q_rs2           = 5'($urandom_range(0, 31));
            tick();
        end
        in_valid = 1'b0; issue_valid = 1'b0; rf_wready = 1'b1;
        repeat (4) tick();

        // Mid-stream reset with two entries held and pending = 0x80.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        rf_wready = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd7; issue_reg_write = 1'b1;
        push_in(5'd9, 1'b1, 1'b0, 64'h99, 64'h0);
        tick();
        issue_valid = 1'b0;
        push_in(5'd10, 1'b1, 1'b0, 64'h1010, 64'h0);
        tick();
        in_valid = 1'b0;
        chk("mid_pending", {32'd0, pending}, 64'h80);
        chk("mid_full", {63'd0, in_ready}, 64'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("arst_rf_we", {63'd0, rf_we}, 64'd0);
        chk("arst_pending", {32'd0, pending}, 64'd0);
        chk("arst_retire", retire_count, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Bypass view of a held head.
        rf_wready = 1'b0;
        push_in(5'd3, 1'b1, 1'b0, 64'h42, 64'h0);
        tick();
        in_valid = 1'b0;
`ifdef WB_BYPASS_EN
        chk("byp_hold_valid", {63'd0, byp_valid}, 64'd1);
        chk("byp_hold_rd", {59'd0, byp_rd}, 64'd3);
        chk("byp_hold_data", byp_data, 64'h42);
`else
        chk("byp_hold_valid", {63'd0, byp_valid}, 64'd0);
        chk("byp_hold_rd", {59'd0, byp_rd}, 64'd0);
        chk("byp_hold_data", byp_data, 64'd0);
`endif
        tick();
        rf_wready = 1'b1;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
